io_port_bridge: RTL and testbench

//  External-side bridge for the core's 16-bit IN/OUT ports. The device->core path buffers

---
 rtl/io_port_bridge.sv | 147 ++++++++++++++
 tb/tb_io_port_bridge.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_bridge.sv
// io_port_bridge: board-side bridge for the core's 16-bit IN/OUT ports.
// Device->core words are buffered in an RX FIFO whose head drives the core's
// input port; core->device words from OUT instructions are buffered in a TX
// FIFO and drained to the device over a valid/ready handshake.
module io_port_bridge #(
    parameter int DATA_W   = 16,
    parameter int RX_DEPTH = 4,
    parameter int TX_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           ext_in_data,
    input  logic                        ext_in_valid,
    output logic                        ext_in_ready,
    output logic [DATA_W-1:0]           core_in_data,
    input  logic                        core_in_read,
    input  logic [DATA_W-1:0]           core_out_data,
    input  logic                        core_out_wr,
    output logic [DATA_W-1:0]           ext_out_data,
    output logic                        ext_out_valid,
    input  logic                        ext_out_ready,
    output logic [$clog2(RX_DEPTH):0]   rx_count,
    output logic [$clog2(TX_DEPTH):0]   tx_count,
    output logic                        rx_underflow,
    output logic                        tx_overflow,
    input  logic                        clear_flags
);

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_CW = RX_AW + 1;
    localparam int TX_CW = TX_AW + 1;
    localparam logic [RX_CW-1:0] RX_FULL_CNT = RX_CW'(RX_DEPTH);
    localparam logic [TX_CW-1:0] TX_FULL_CNT = TX_CW'(TX_DEPTH);

    // Storage
    logic [DATA_W-1:0] rx_mem_q [RX_DEPTH];
    logic [DATA_W-1:0] tx_mem_q [TX_DEPTH];

    // Pointers, occupancy and sticky flags
    logic [RX_AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [TX_AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [RX_CW-1:0] rx_count_q, rx_count_d;
    logic [TX_CW-1:0] tx_count_q, tx_count_d;
    logic             rx_underflow_q, rx_underflow_d;
    logic             tx_overflow_q, tx_overflow_d;

    // Handshake qualifiers
    logic rx_full, rx_empty, tx_full, tx_empty;
    logic rx_push, rx_pop, rx_read_empty;
    logic tx_push, tx_pop, tx_drop;

    assign rx_full  = (rx_count_q == RX_FULL_CNT);
    assign rx_empty = (rx_count_q == '0);
    assign tx_full  = (tx_count_q == TX_FULL_CNT);
    assign tx_empty = (tx_count_q == '0);

    // Ready depends only on registered occupancy, so the device never sees a
    // combinational path back from its own valid or from the core side.
    assign ext_in_ready  = !rst && !rx_full;
    assign rx_push       = ext_in_valid && ext_in_ready;
    // A word pushed this same cycle cannot satisfy a read of an empty FIFO.
    assign rx_pop        = core_in_read && !rx_empty;
    assign rx_read_empty = core_in_read && rx_empty;

    assign ext_out_valid = !tx_empty;
    assign tx_pop        = ext_out_valid && ext_out_ready;
    // When full, a write still fits if the head leaves in the same cycle.
    assign tx_push       = core_out_wr && (!tx_full || tx_pop);
    assign tx_drop       = core_out_wr && !tx_push;

    assign core_in_data = rx_empty ? '0 : rx_mem_q[rx_rd_ptr_q];
    assign ext_out_data = tx_empty ? '0 : tx_mem_q[tx_rd_ptr_q];

    assign rx_count     = rx_count_q;
    assign tx_count     = tx_count_q;
    assign rx_underflow = rx_underflow_q;
    assign tx_overflow  = tx_overflow_q;

    // Next-state for pointers, occupancy and sticky flags of both FIFOs
    always_comb begin
        // NOTE: every signal gets a default here first so no path can infer a latch.
        rx_wr_ptr_d    = rx_wr_ptr_q;
        rx_rd_ptr_d    = rx_rd_ptr_q;
        rx_count_d     = rx_count_q;
        rx_underflow_d = rx_underflow_q;
        tx_wr_ptr_d    = tx_wr_ptr_q;
        tx_rd_ptr_d    = tx_rd_ptr_q;
        tx_count_d     = tx_count_q;
        tx_overflow_d  = tx_overflow_q;

        if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + RX_AW'(1);
        if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + RX_AW'(1);
        case ({rx_push, rx_pop})
            2'b10:   rx_count_d = rx_count_q + RX_CW'(1);
            2'b01:   rx_count_d = rx_count_q - RX_CW'(1);
            default: rx_count_d = rx_count_q;
        endcase

        if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + TX_AW'(1);
        if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + TX_AW'(1);
        case ({tx_push, tx_pop})
            2'b10:   tx_count_d = tx_count_q + TX_CW'(1);
            2'b01:   tx_count_d = tx_count_q - TX_CW'(1);
            default: tx_count_d = tx_count_q;
        endcase

        // A new error event wins over a clear requested in the same cycle.
        if (rx_read_empty)    rx_underflow_d = 1'b1;
        else if (clear_flags) rx_underflow_d = 1'b0;

        if (tx_drop)          tx_overflow_d = 1'b1;
        else if (clear_flags) tx_overflow_d = 1'b0;
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            rx_wr_ptr_q    <= '0;
            rx_rd_ptr_q    <= '0;
            rx_count_q     <= '0;
            rx_underflow_q <= 1'b0;
            tx_wr_ptr_q    <= '0;
            tx_rd_ptr_q    <= '0;
            tx_count_q     <= '0;
            tx_overflow_q  <= 1'b0;
        end else begin
            rx_wr_ptr_q    <= rx_wr_ptr_d;
            rx_rd_ptr_q    <= rx_rd_ptr_d;
            rx_count_q     <= rx_count_d;
            rx_underflow_q <= rx_underflow_d;
            tx_wr_ptr_q    <= tx_wr_ptr_d;
            tx_rd_ptr_q    <= tx_rd_ptr_d;
            tx_count_q     <= tx_count_d;
            tx_overflow_q  <= tx_overflow_d;
        end
    end

    // FIFO data storage writes
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; outputs are masked to zero while a FIFO is empty.
        if (rx_push) rx_mem_q[rx_wr_ptr_q] <= ext_in_data;
        if (tx_push) tx_mem_q[tx_wr_ptr_q] <= core_out_data;
    end

endmodule

// File: tb/tb_io_port_bridge.sv
// Self-checking bench for io_port_bridge: directed scenarios plus a randomized
// stream, checked against a queue-based model of the two FIFOs and flags.
module tb_io_port_bridge;

    localparam int DATA_W   = 16;
    localparam int RX_DEPTH = 4;
    localparam int TX_DEPTH = 4;
    localparam int RX_CW    = $clog2(RX_DEPTH) + 1;
    localparam int TX_CW    = $clog2(TX_DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] ext_in_data;
    logic              ext_in_valid;
    logic              ext_in_ready;
    logic [DATA_W-1:0] core_in_data;
    logic              core_in_read;
    logic [DATA_W-1:0] core_out_data;
    logic              core_out_wr;
    logic [DATA_W-1:0] ext_out_data;
    logic              ext_out_valid;
    logic              ext_out_ready;
    logic [RX_CW-1:0]  rx_count;
    logic [TX_CW-1:0]  tx_count;
    logic              rx_underflow;
    logic              tx_overflow;
    logic              clear_flags;

    io_port_bridge #(.DATA_W(DATA_W), .RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .ext_in_data  (ext_in_data),
        .ext_in_valid (ext_in_valid),
        .ext_in_ready (ext_in_ready),
        .core_in_data (core_in_data),
        .core_in_read (core_in_read),
        .core_out_data(core_out_data),
        .core_out_wr  (core_out_wr),
        .ext_out_data (ext_out_data),
        .ext_out_valid(ext_out_valid),
        .ext_out_ready(ext_out_ready),
        .rx_count     (rx_count),
        .tx_count     (tx_count),
        .rx_underflow (rx_underflow),
        .tx_overflow  (tx_overflow),
        .clear_flags  (clear_flags)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain queues holding what each FIFO should contain.
    logic [DATA_W-1:0] rx_m[$];
    logic [DATA_W-1:0] tx_m[$];
    bit                unf_m;
    bit                ovf_m;

    // Words seen leaving the DUT alongside what the model says should leave.
    logic [DATA_W-1:0] obs_rx[$];
    logic [DATA_W-1:0] exp_rx[$];
    logic [DATA_W-1:0] obs_tx[$];
    logic [DATA_W-1:0] exp_tx[$];

    task automatic idle_inputs();
        ext_in_valid  = 1'b0;
        ext_in_data   = '0;
        core_in_read  = 1'b0;
        core_out_wr   = 1'b0;
        core_out_data = '0;
        ext_out_ready = 1'b0;
        clear_flags   = 1'b0;
    endtask

    task automatic clear_logs();
        obs_rx.delete();
        exp_rx.delete();
        obs_tx.delete();
        exp_tx.delete();
    endtask

    // Apply the current inputs for one clock: update the model from its own
    // pre-edge state, log outgoing words, then advance to 1 time unit past the edge.
    task automatic step();
        bit rx_push, rx_pop, set_unf, tx_pop, tx_push, set_ovf;
        rx_push = ext_in_valid && (rx_m.size() < RX_DEPTH);
        rx_pop  = core_in_read && (rx_m.size() != 0);
        set_unf = core_in_read && (rx_m.size() == 0);
        tx_pop  = ext_out_ready && (tx_m.size() != 0);
        tx_push = core_out_wr && ((tx_m.size() < TX_DEPTH) || tx_pop);
        set_ovf = core_out_wr && !tx_push;
        if (rx_pop) begin
            obs_rx.push_back(core_in_data);
            exp_rx.push_back(rx_m.pop_front());
        end
        if (rx_push) rx_m.push_back(ext_in_data);
        if (tx_pop) begin
            obs_tx.push_back(ext_out_data);
            exp_tx.push_back(tx_m.pop_front());
        end
        if (tx_push) tx_m.push_back(core_out_data);
        unf_m = set_unf ? 1'b1 : (clear_flags ? 1'b0 : unf_m);
        ovf_m = set_ovf ? 1'b1 : (clear_flags ? 1'b0 : ovf_m);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst          = 1'b1;
        ext_in_valid = 1'b1;
        ext_in_data  = 16'h1234;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (ext_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 0", ext_in_ready);
        end
        n_checks++;
        if ({core_in_data, ext_out_data, ext_out_valid} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: core_in=%h ext_out=%h valid=%b expected all 0",
                     core_in_data, ext_out_data, ext_out_valid);
        end
        rst          = 1'b0;
        ext_in_valid = 1'b0;
        #1;
        n_checks++;
        if ({rx_count, tx_count, rx_underflow, tx_overflow, ext_out_valid} !== '0) begin
            n_fail++;
            $display("FAIL reset_release_state: rx=%0d tx=%0d unf=%b ovf=%b valid=%b expected 0",
                     rx_count, tx_count, rx_underflow, tx_overflow, ext_out_valid);
        end
        n_checks++;
        if (ext_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b expected 1", ext_in_ready);
        end
        rx_m.delete();
        tx_m.delete();
        unf_m = 1'b0;
        ovf_m = 1'b0;
    endtask

    task automatic test_rx_fill();
        clear_logs();
        idle_inputs();
        for (int i = 1; i <= 5; i++) begin
            ext_in_valid = 1'b1;
            ext_in_data  = DATA_W'(i);
            step();
            if (i == 1) begin
                n_checks++;
                if (core_in_data !== 16'd1) begin
                    n_fail++;
                    $display("FAIL rx_latency: core_in_data=%0d expected 1", core_in_data);
                end
            end
        end
        ext_in_valid = 1'b0;
        n_checks++;
        if (rx_count !== RX_CW'(4) || ext_in_ready !== 1'b0 || core_in_data !== 16'd1) begin
            n_fail++;
            $display("FAIL rx_full: count=%0d ready=%b head=%0d expected 4/0/1",
                     rx_count, ext_in_ready, core_in_data);
        end
        core_in_read = 1'b1;
        repeat (4) step();
        core_in_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= obs_rx.size() || obs_rx[i] !== DATA_W'(i + 1)) begin
                n_fail++;
                $display("FAIL rx_order[%0d]: got %0d expected %0d", i,
                         (i < obs_rx.size()) ? obs_rx[i] : '1, i + 1);
            end
        end
        n_checks++;
        if (rx_count !== '0 || rx_underflow !== 1'b0 || core_in_data !== '0) begin
            n_fail++;
            $display("FAIL rx_drained: count=%0d unf=%b head=%h expected 0/0/0",
                     rx_count, rx_underflow, core_in_data);
        end
    endtask

    task automatic test_rx_underflow();
        idle_inputs();
        core_in_read = 1'b1;
        step();
        core_in_read = 1'b0;
        n_checks++;
        if (rx_underflow !== 1'b1 || rx_count !== '0) begin
            n_fail++;
            $display("FAIL rx_underflow_set: unf=%b count=%0d expected 1/0", rx_underflow, rx_count);
        end
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        n_checks++;
        if (rx_underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL rx_underflow_clear: got %b expected 0", rx_underflow);
        end
        // Read of empty FIFO together with a push and a clear: flag set wins, push lands.
        core_in_read = 1'b1;
        ext_in_valid = 1'b1;
        ext_in_data  = 16'hBEEF;
        clear_flags  = 1'b1;
        step();
        idle_inputs();
        n_checks++;
        if (rx_underflow !== 1'b1 || rx_count !== RX_CW'(1) || core_in_data !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL rx_underflow_priority: unf=%b count=%0d head=%h expected 1/1/beef",
                     rx_underflow, rx_count, core_in_data);
        end
        core_in_read = 1'b1;
        clear_flags  = 1'b1;
        step();
        idle_inputs();
        n_checks++;
        if (rx_underflow !== unf_m || rx_count !== RX_CW'(rx_m.size())) begin
            n_fail++;
            $display("FAIL rx_cleanup: unf=%b count=%0d expected %b/%0d",
                     rx_underflow, rx_count, unf_m, rx_m.size());
        end
    endtask

    task automatic test_tx_backpressure();
        clear_logs();
        idle_inputs();
        for (int i = 1; i <= 5; i++) begin
            core_out_wr   = 1'b1;
            core_out_data = 16'h00A0 + DATA_W'(i);
            step();
        end
        core_out_wr = 1'b0;
        n_checks++;
        if (tx_count !== TX_CW'(4) || tx_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_overflow: count=%0d ovf=%b expected 4/1", tx_count, tx_overflow);
        end
        step();
        n_checks++;
        if (ext_out_valid !== 1'b1 || ext_out_data !== 16'h00A1) begin
            n_fail++;
            $display("FAIL tx_stable: valid=%b data=%h expected 1/00a1", ext_out_valid, ext_out_data);
        end
        ext_out_ready = 1'b1;
        clear_flags   = 1'b1;
        repeat (4) step();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= obs_tx.size() || obs_tx[i] !== 16'h00A1 + DATA_W'(i)) begin
                n_fail++;
                $display("FAIL tx_order[%0d]: got %h expected %h", i,
                         (i < obs_tx.size()) ? obs_tx[i] : '1, 16'h00A1 + DATA_W'(i));
            end
        end
        n_checks++;
        if (tx_count !== '0 || ext_out_valid !== 1'b0 || ext_out_data !== '0 || tx_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL tx_drained: count=%0d valid=%b data=%h ovf=%b expected 0",
                     tx_count, ext_out_valid, ext_out_data, tx_overflow);
        end
    endtask

    task automatic test_tx_full_wr_pop();
        clear_logs();
        idle_inputs();
        for (int i = 1; i <= 4; i++) begin
            core_out_wr   = 1'b1;
            core_out_data = 16'h00B0 + DATA_W'(i);
            step();
        end
        core_out_data = 16'h00B5;
        ext_out_ready = 1'b1;
        step();
        core_out_wr = 1'b0;
        n_checks++;
        if (tx_count !== TX_CW'(4) || tx_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL tx_full_wr_pop: count=%0d ovf=%b expected 4/0", tx_count, tx_overflow);
        end
        repeat (4) step();
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (i >= obs_tx.size() || obs_tx[i] !== 16'h00B1 + DATA_W'(i)) begin
                n_fail++;
                $display("FAIL tx_full_order[%0d]: got %h expected %h", i,
                         (i < obs_tx.size()) ? obs_tx[i] : '1, 16'h00B1 + DATA_W'(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        ext_in_valid  = 1'b1;
        ext_in_data   = 16'h0C01;
        core_out_wr   = 1'b1;
        core_out_data = 16'h0D01;
        repeat (2) step();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({rx_count, tx_count, ext_out_valid, ext_in_ready, core_in_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: rx=%0d tx=%0d valid=%b ready=%b head=%h expected 0",
                     rx_count, tx_count, ext_out_valid, ext_in_ready, core_in_data);
        end
        @(posedge clk);
        #1;
        idle_inputs();
        rst = 1'b0;
        rx_m.delete();
        tx_m.delete();
        unf_m = 1'b0;
        ovf_m = 1'b0;
        step();
        n_checks++;
        if ({rx_count, tx_count, ext_out_valid} !== '0 || ext_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_release: rx=%0d tx=%0d valid=%b ready=%b expected 0/0/0/1",
                     rx_count, tx_count, ext_out_valid, ext_in_ready);
        end
    endtask

    task automatic test_wrap();
        int bad_cycles = 0;
        int bad_words  = 0;
        clear_logs();
        for (int c = 0; c < 200; c++) begin
            ext_in_valid  = 1'($urandom_range(0, 1));
            ext_in_data   = DATA_W'($urandom);
            core_in_read  = ($urandom_range(0, 2) == 0);
            core_out_wr   = 1'($urandom_range(0, 1));
            core_out_data = DATA_W'($urandom);
            ext_out_ready = 1'($urandom_range(0, 1));
            clear_flags   = ($urandom_range(0, 7) == 0);
            #1;
            n_checks++;
            if (ext_in_ready !== (rx_m.size() < RX_DEPTH) || ext_out_valid !== (tx_m.size() != 0) ||
                ext_out_data !== ((tx_m.size() != 0) ? tx_m[0] : '0) ||
                core_in_data !== ((rx_m.size() != 0) ? rx_m[0] : '0)) begin
                n_fail++;
                bad_cycles++;
                if (bad_cycles < 5)
                    $display("FAIL wrap_handshake[%0d]: ready=%b valid=%b out=%h in=%h", c,
                             ext_in_ready, ext_out_valid, ext_out_data, core_in_data);
            end
            step();
            n_checks++;
            if (rx_count !== RX_CW'(rx_m.size()) || tx_count !== TX_CW'(tx_m.size()) ||
                rx_underflow !== unf_m || tx_overflow !== ovf_m) begin
                n_fail++;
                bad_cycles++;
                if (bad_cycles < 5)
                    $display("FAIL wrap_state[%0d]: rx=%0d/%0d tx=%0d/%0d unf=%b/%b ovf=%b/%b (got/expected)",
                             c, rx_count, rx_m.size(), tx_count, tx_m.size(),
                             rx_underflow, unf_m, tx_overflow, ovf_m);
            end
        end
        idle_inputs();
        ext_out_ready = 1'b1;
        for (int c = 0; c < 20 && (rx_m.size() != 0 || tx_m.size() != 0); c++) begin
            core_in_read = (rx_m.size() != 0);
            step();
        end
        idle_inputs();
        n_checks++;
        if (rx_count !== '0 || tx_count !== '0 || obs_rx.size() < 10 || obs_tx.size() < 10) begin
            n_fail++;
            $display("FAIL wrap_drain: rx=%0d tx=%0d words_rx=%0d words_tx=%0d expected 0/0/>=10/>=10",
                     rx_count, tx_count, obs_rx.size(), obs_tx.size());
        end
        for (int i = 0; i < obs_rx.size(); i++) begin
            if (obs_rx[i] !== exp_rx[i]) begin
                bad_words++;
                if (bad_words < 5) $display("FAIL wrap_rx_word[%0d]: got %h expected %h", i, obs_rx[i], exp_rx[i]);
            end
        end
        for (int i = 0; i < obs_tx.size(); i++) begin
            if (obs_tx[i] !== exp_tx[i]) begin
                bad_words++;
                if (bad_words < 5) $display("FAIL wrap_tx_word[%0d]: got %h expected %h", i, obs_tx[i], exp_tx[i]);
            end
        end
        n_checks++;
        if (bad_words != 0) begin
            n_fail++;
            $display("FAIL wrap_order: %0d words out of order, expected 0", bad_words);
        end
    endtask

    initial begin
        test_reset();
        test_rx_fill();
        test_rx_underflow();
        test_tx_backpressure();
        test_tx_full_wr_pop();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
